// File: rtl/nexys_starship_rng_if.sv
// Signal bundle between the break-event generator (master) and the repair blocks (slave).
interface nexys_starship_rng_if;
  logic       play_flag;
  logic       gameover_ctrl;
  logic       timer_clk;
  logic [3:0] random_hex;
  logic       RR_random;
  logic       RL_random;
  logic       RU_random;
  logic       RD_random;
  logic [2:0] difficulty;

  modport master (
    input  play_flag, gameover_ctrl,
    output timer_clk, random_hex, RR_random, RL_random, RU_random, RD_random, difficulty
  );

  modport slave (
    output play_flag, gameover_ctrl,
    input  timer_clk, random_hex, RR_random, RL_random, RU_random, RD_random, difficulty
  );
endinterface

// File: rtl/nexys_starship_rng.sv
// Break-event source for the repair FSMs: LFSR-driven part strobes, held combo, timer_clk, difficulty ramp.
// Strobes appear one Clk after a roll; define NEXYS_STARSHIP_NO_REPEAT_EN to steer a repeat break to the next part.
module nexys_starship_rng #(
  parameter int          TICK_DIV    = 100_000_000,
  parameter int          ROLL_DIV    = 25_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [8:0]  BASE_THRESH = 9'd16,
  parameter logic [8:0]  RAMP_STEP   = 9'd8,
  parameter int          DIFF_TICKS  = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  nexys_starship_rng_if.master bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(ROLL_DIV);
  localparam int DW = $clog2(DIFF_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV / 2 - 1);
  localparam logic [RW-1:0] ROLL_LAST = RW'(ROLL_DIV - 1);
  localparam logic [DW-1:0] DIFF_LAST = DW'(DIFF_TICKS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tick_cnt_q;
  logic          timer_q, timer_prev_q;
  logic [RW-1:0] roll_cnt_q;
  logic [DW-1:0] dtick_q;
  logic [2:0]    diff_q;
  logic [3:0]    hex_q;
  logic [3:0]    strb_q, strb_d;
  logic [9:0]    thresh_w;
  logic [8:0]    thresh;
  logic [1:0]    sel;
  logic          clear_run, roll_now, hit, timer_rise;

`ifdef NEXYS_STARSHIP_NO_REPEAT_EN
  logic [1:0] last_q;
  logic       fired_q;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Gameover wins over play_flag when both are high in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.play_flag && !bus.gameover_ctrl) state_d = RUN;
      RUN:     if (bus.gameover_ctrl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_run  = (state_q == IDLE) || bus.gameover_ctrl;
    roll_now   = !clear_run && (roll_cnt_q == ROLL_LAST);
    thresh_w   = {1'b0, BASE_THRESH} + 10'(diff_q) * {1'b0, RAMP_STEP};
    thresh     = (thresh_w > 10'd256) ? 9'd256 : thresh_w[8:0];
    hit        = {1'b0, lfsr_q[7:0]} < thresh;
    timer_rise = timer_q && !timer_prev_q;
    sel        = lfsr_q[9:8];
`ifdef NEXYS_STARSHIP_NO_REPEAT_EN
    if (fired_q && sel == last_q) sel = sel + 2'd1;
`endif
    strb_d = 4'b0000;
    if (roll_now && hit) strb_d = 4'b0001 << sel;
    // Zero is the only lockup state of this polynomial; reseed out of it.
    if (lfsr_q == 16'd0) lfsr_d = LFSR_SEED;
    else                 lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q       <= LFSR_SEED;
      tick_cnt_q   <= '0;
      timer_q      <= 1'b0;
      timer_prev_q <= 1'b0;
      roll_cnt_q   <= '0;
      dtick_q      <= '0;
      diff_q       <= 3'd0;
      hex_q        <= 4'd0;
      strb_q       <= 4'd0;
    end else begin
      lfsr_q       <= lfsr_d;
      timer_prev_q <= timer_q;
      strb_q       <= strb_d;
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_q <= '0;
        timer_q    <= ~timer_q;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (strb_d != 4'd0) hex_q <= lfsr_q[15:12];
      if (clear_run) begin
        roll_cnt_q <= '0;
        dtick_q    <= '0;
        diff_q     <= 3'd0;
      end else begin
        roll_cnt_q <= (roll_cnt_q == ROLL_LAST) ? '0 : roll_cnt_q + 1'b1;
        if (timer_rise) begin
          if (dtick_q == DIFF_LAST) begin
            dtick_q <= '0;
            if (diff_q != 3'd7) diff_q <= diff_q + 3'd1;
          end else begin
            dtick_q <= dtick_q + 1'b1;
          end
        end
      end
    end
  end

`ifdef NEXYS_STARSHIP_NO_REPEAT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_q  <= 2'd0;
      fired_q <= 1'b0;
    end else if (clear_run) begin
      last_q  <= 2'd0;
      fired_q <= 1'b0;
    end else if (strb_d != 4'd0) begin
      last_q  <= sel;
      fired_q <= 1'b1;
    end
  end
`endif

  // A registered strobe is still hidden in the cycle gameover is seen.
  assign bus.timer_clk  = timer_q;
  assign bus.random_hex = hex_q;
  assign bus.difficulty = diff_q;
  assign bus.RR_random  = strb_q[0] & ~bus.gameover_ctrl;
  assign bus.RL_random  = strb_q[1] & ~bus.gameover_ctrl;
  assign bus.RU_random  = strb_q[2] & ~bus.gameover_ctrl;
  assign bus.RD_random  = strb_q[3] & ~bus.gameover_ctrl;

endmodule

// File: tb/tb_nexys_starship_rng.sv
// Bench for nexys_starship_rng: directed phase table, hand sequences, and a per-cycle scoreboard over
// three threshold configurations (always-break with clamp, never-break, ramping).
module tb_nexys_starship_rng;

  localparam int          TICK = 4;
  localparam int          HALF = TICK / 2;
  localparam int          ROLL = 8;
  localparam int          DIFF = 2;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef NEXYS_STARSHIP_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic play, go;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  nexys_starship_rng_if if_a ();
  nexys_starship_rng_if if_b ();
  nexys_starship_rng_if if_c ();

  assign if_a.play_flag = play;  assign if_a.gameover_ctrl = go;
  assign if_b.play_flag = play;  assign if_b.gameover_ctrl = go;
  assign if_c.play_flag = play;  assign if_c.gameover_ctrl = go;

  nexys_starship_rng #(.TICK_DIV(TICK), .ROLL_DIV(ROLL), .LFSR_SEED(SEED), .BASE_THRESH(9'd256),
                       .RAMP_STEP(9'd8), .DIFF_TICKS(DIFF)) dut_a (.Clk(Clk), .Reset(Reset), .bus(if_a));
  nexys_starship_rng #(.TICK_DIV(TICK), .ROLL_DIV(ROLL), .LFSR_SEED(SEED), .BASE_THRESH(9'd0),
                       .RAMP_STEP(9'd0), .DIFF_TICKS(DIFF)) dut_b (.Clk(Clk), .Reset(Reset), .bus(if_b));
  nexys_starship_rng #(.TICK_DIV(TICK), .ROLL_DIV(ROLL), .LFSR_SEED(SEED), .BASE_THRESH(9'd16),
                       .RAMP_STEP(9'd32), .DIFF_TICKS(DIFF)) dut_c (.Clk(Clk), .Reset(Reset), .bus(if_c));

  logic [3:0] strb_a, strb_b, strb_c;
  assign strb_a = {if_a.RD_random, if_a.RU_random, if_a.RL_random, if_a.RR_random};
  assign strb_b = {if_b.RD_random, if_b.RU_random, if_b.RL_random, if_b.RR_random};
  assign strb_c = {if_c.RD_random, if_c.RU_random, if_c.RL_random, if_c.RR_random};

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int base_of(input int i);
    case (i)
      0:       return 256;
      1:       return 0;
      default: return 16;
    endcase
  endfunction

  function automatic int ramp_of(input int i);
    case (i)
      0:       return 8;
      1:       return 0;
      default: return 32;
    endcase
  endfunction

  function automatic int thr(input int i, input int d);
    int t;
    t = base_of(i) + d * ramp_of(i);
    return (t > 256) ? 256 : t;
  endfunction

  // timer_clk level after c Clk edges since reset release.
  function automatic int tcv(input int c);
    return (c / HALF) % 2;
  endfunction

  function automatic bit is_rise(input int c);
    return (c > 0) && tcv(c) == 1 && tcv(c - 1) == 0;
  endfunction

  function automatic logic [1:0] pick_sel(input logic [15:0] l, input bit fired, input logic [1:0] last);
    logic [1:0] s;
    s = l[9:8];
    if (NO_REPEAT && fired && s == last) s = s + 2'd1;
    return s;
  endfunction

  // Golden model: m_c counts edges since reset, m_k counts RUN edges since the game started.
  logic [15:0] m_lfsr;
  int          m_c, m_k, m_rises, m_diff;
  bit          m_run;
  logic [3:0]  m_strb [3];
  logic [3:0]  m_hex  [3];
  logic [1:0]  m_last [3];
  bit          m_fired[3];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr <= SEED; m_c <= 0; m_k <= 0; m_rises <= 0; m_diff <= 0; m_run <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_strb[i] <= 4'd0; m_hex[i] <= 4'd0; m_last[i] <= 2'd0; m_fired[i] <= 1'b0;
      end
    end else begin
      m_lfsr <= (m_lfsr == 16'd0) ? SEED
                : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_c <= m_c + 1;
      if (!m_run || go) begin
        m_run <= !m_run && play && !go;
        m_k <= 0; m_rises <= 0; m_diff <= 0;
        for (int i = 0; i < 3; i++) begin
          m_strb[i] <= 4'd0; m_last[i] <= 2'd0; m_fired[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if ((m_k % ROLL) == ROLL - 1 && int'(m_lfsr[7:0]) < thr(i, m_diff)) begin
            m_strb[i]  <= 4'b0001 << pick_sel(m_lfsr, m_fired[i], m_last[i]);
            m_last[i]  <= pick_sel(m_lfsr, m_fired[i], m_last[i]);
            m_fired[i] <= 1'b1;
            m_hex[i]   <= m_lfsr[15:12];
          end else begin
            m_strb[i] <= 4'd0;
          end
        end
        m_k <= m_k + 1;
        if (is_rise(m_c)) begin
          m_rises <= m_rises + 1;
          m_diff  <= ((m_rises + 1) / DIFF >= 7) ? 7 : (m_rises + 1) / DIFF;
        end
      end
    end
  end

  task automatic sb(input string nm, input int i, input logic tc, input logic [3:0] s,
                    input logic [3:0] h, input logic [2:0] d);
    check({nm, "_tc"},   tc, tcv(m_c));
    check({nm, "_strb"}, s,  m_strb[i] & {4{~go}});
    check({nm, "_hex"},  h,  m_hex[i]);
    check({nm, "_diff"}, d,  m_diff);
  endtask

  always @(negedge Clk) begin
    sb("sb_a", 0, if_a.timer_clk, strb_a, if_a.random_hex, if_a.difficulty);
    sb("sb_b", 1, if_b.timer_clk, strb_b, if_b.random_hex, if_b.difficulty);
    sb("sb_c", 2, if_c.timer_clk, strb_c, if_c.random_hex, if_c.difficulty);
  end

  bit         count_en = 1'b0;
  int         cnt_a = 0, cnt_b = 0;
  logic [3:0] prev_a = 4'd0;

  always @(negedge Clk) begin
    if (count_en) begin
      if (strb_a != 4'd0) begin
        cnt_a  <= cnt_a + 1;
        prev_a <= strb_a;
`ifdef NEXYS_STARSHIP_NO_REPEAT_EN
        check("norepeat_a", int'(strb_a == prev_a), 0);
`endif
      end
      if (strb_b != 4'd0) cnt_b <= cnt_b + 1;
    end
  end

  typedef struct {
    bit rst;
    bit play;
    bit go;
    int n;
    int exp_tc;
    int exp_diff;
    int exp_any_a;
  } vec_t;

  vec_t vt [12];

  initial begin
    Reset = 1'b1; play = 1'b0; go = 1'b0;
    //           rst play go   n  tc diff any_a
    vt[0]  = '{1'b1, 1'b0, 1'b0,   3, 0, 0, 0};
    vt[1]  = '{1'b0, 1'b0, 1'b0,   2, 1, 0, 0};
    vt[2]  = '{1'b0, 1'b0, 1'b0,   1, 1, 0, 0};
    vt[3]  = '{1'b0, 1'b0, 1'b0,   1, 0, 0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b0,   1, 0, 0, 0};
    vt[5]  = '{1'b0, 1'b0, 1'b0,   8, 0, 1, 1};
    vt[6]  = '{1'b0, 1'b0, 1'b0,  16, 0, 3, 1};
    vt[7]  = '{1'b0, 1'b0, 1'b1,   1, 1, 0, 0};
    vt[8]  = '{1'b0, 1'b1, 1'b1,   3, 0, 0, 0};
    vt[9]  = '{1'b0, 1'b0, 1'b0,  20, 0, 0, 0};
    vt[10] = '{1'b0, 1'b1, 1'b0,   1, 1, 0, 0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 200, 1, 7, 1};

    for (int v = 0; v < 12; v++) begin
      Reset = vt[v].rst; play = vt[v].play; go = vt[v].go;
      repeat (vt[v].n) @(posedge Clk);
      #1;
      check($sformatf("v%0d_tc", v),     if_a.timer_clk,   vt[v].exp_tc);
      check($sformatf("v%0d_diff_a", v), if_a.difficulty,  vt[v].exp_diff);
      check($sformatf("v%0d_diff_b", v), if_b.difficulty,  vt[v].exp_diff);
      check($sformatf("v%0d_any_a", v),  int'(|strb_a),    vt[v].exp_any_a);
      check($sformatf("v%0d_any_b", v),  int'(|strb_b),    0);
    end

    // Gameover landing exactly on a roll cycle must swallow that roll.
    repeat (7) @(posedge Clk);
    #1 go = 1'b1;
    @(posedge Clk);
    #1 go = 1'b0;
    #1;
    check("go_roll_strb_a", strb_a, 0);
    check("go_roll_diff_a", if_a.difficulty, 0);
    repeat (10) @(posedge Clk);
    #1;
    check("idle_after_go_a", strb_a, 0);

    // Reset while a strobe is showing clears everything immediately.
    play = 1'b1;
    @(posedge Clk);
    #1 play = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    check("pending_any_a", int'(|strb_a), 1);
    Reset = 1'b1;
    #1;
    check("rst_strb_a", strb_a, 0);
    check("rst_hex_a",  if_a.random_hex, 0);
    check("rst_hex_c",  if_c.random_hex, 0);
    check("rst_tc_a",   if_a.timer_clk, 0);
    check("rst_diff_a", if_a.difficulty, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    check("post_rst_idle_a", strb_a, 0);
    play = 1'b1;
    @(posedge Clk);
    #1 play = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    check("restart_any_a", int'(|strb_a), 1);
    check("restart_hex_a", if_a.random_hex, m_hex[0]);

    // 1000 roll periods: always-break fires every roll, zero threshold never fires.
    count_en = 1'b1;
    repeat (ROLL * 1000) @(posedge Clk);
    #1 count_en = 1'b0;
    check("long_cnt_a",  cnt_a, 1000);
    check("long_cnt_b",  cnt_b, 0);
    check("long_diff_b", if_b.difficulty, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
